// File: rtl/data_mem_responder_pkg.sv
// Shared widths, latency bounds and FSM encoding for the data-memory responder.
// Pure declarations: no logic, no latency, no backpressure.
package data_mem_responder_pkg;

    localparam int WORD_W      = 16;
    localparam int DMEM_ADDR_W = 15;
    localparam int PORT_ADDR_W = 16;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic latency_legal(input int lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word storage: synchronous write, synchronous read, write-through echo.
// One-cycle read latency when en is high; no backpressure, accepts an access every cycle.
module data_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DATA_W    = WORD_W,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Output register holds the last result until the next access; a store echoes its data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle ld/st responder: accepts req in IDLE, acks LATENCY edges after acceptance.
// Initiator holds req until ack; req is ignored while busy, so one request is in flight at a time.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DATA_W    = WORD_W,
    parameter int LATENCY   = 2,
    parameter     INIT_FILE = ""
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req,
    input  logic                   wnotr,
    input  logic [PORT_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic                   ack,
    output logic [DATA_W-1:0]      rdata,
    output logic                   busy
);

    if (!latency_legal(LATENCY) || ADDR_W < 1 || ADDR_W > PORT_ADDR_W) begin : g_bad_param
        $error("data_mem_responder: LATENCY or ADDR_W out of range");
    end

    // Upper address bits alias onto the array.
    if (ADDR_W < PORT_ADDR_W) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[PORT_ADDR_W-1:ADDR_W];
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               cap_wnotr;
    logic [ADDR_W-1:0]  cap_addr;
    logic [DATA_W-1:0]  cap_wdata;
    logic               access;

    assign access = (state == WAIT) && (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            cap_wnotr <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_wnotr <= wnotr;
                        cap_addr  <= addr[ADDR_W-1:0];
                        cap_wdata <= wdata;
                        cnt       <= CNT_W'(LATENCY - 1);
                        state     <= WAIT;
                        busy      <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                        ack   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                // req is deliberately not looked at here; the initiator drops it by the end of ack.
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    data_mem_array #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (access),
        .we    (cap_wnotr),
        .addr  (cap_addr),
        .wdata (cap_wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 vector table with scoreboard, plus LATENCY=1 and 15 builds.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        req, wnotr, ack, busy;
    logic [15:0] addr, wdata, rdata;
    logic        req1, wnotr1, ack1, busy1;
    logic [15:0] addr1, wdata1, rdata1;
    logic        req15, wnotr15, ack15, busy15;
    logic [15:0] addr15, wdata15, rdata15;

    data_mem_responder #(.LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req(req), .wnotr(wnotr), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy)
    );

    data_mem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .wnotr(wnotr1), .addr(addr1),
        .wdata(wdata1), .ack(ack1), .rdata(rdata1), .busy(busy1)
    );

    data_mem_responder #(.LATENCY(15)) dut15 (
        .clk(clk), .reset(reset), .req(req15), .wnotr(wnotr15), .addr(addr15),
        .wdata(wdata15), .ack(ack15), .rdata(rdata15), .busy(busy15)
    );

    int n_total = 0;
    int n_pass  = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] e;
        logic        perturb;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard: every ack of the LATENCY=2 unit must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ack: got ack=1 rdata=%h, required no ack", rdata);
            end else begin
                check("scoreboard_rdata", {16'h0, rdata}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic run_req(input vec_t v);
        int lat;
        lat = -1;
        @(negedge clk);
        req = 1'b1; wnotr = v.w; addr = v.a; wdata = v.d;
        exp_q.push_back(v.e);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("busy_after_accept", {31'h0, busy}, 32'd1);
                req = 1'b0;
                if (v.perturb) begin
                    addr = 16'h0012; wdata = 16'h2222; wnotr = ~v.w;
                end
            end
            if (ack === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("ack_latency", lat, 32'd2);
        @(negedge clk);
        check("ack_single_cycle", {31'h0, ack}, 32'd0);
        check("idle_after_resp", {31'h0, busy}, 32'd0);
        check("rdata_held", {16'h0, rdata}, {16'h0, v.e});
    endtask

    initial begin
        int ackmask;
        int first;
        int nacks;

        vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'hBEEF, 1'b0};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2]  = '{1'b0, 16'h8010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[3]  = '{1'b1, 16'h0012, 16'h0BAD, 16'h0BAD, 1'b0};
        vecs[4]  = '{1'b1, 16'h0011, 16'h1111, 16'h1111, 1'b1};
        vecs[5]  = '{1'b0, 16'h0011, 16'h0000, 16'h1111, 1'b0};
        vecs[6]  = '{1'b0, 16'h0012, 16'h0000, 16'h0BAD, 1'b0};
        vecs[7]  = '{1'b1, 16'h0020, 16'h5555, 16'h5555, 1'b0};
        vecs[8]  = '{1'b1, 16'h7FFF, 16'hA5A5, 16'hA5A5, 1'b0};
        vecs[9]  = '{1'b0, 16'hFFFF, 16'h0000, 16'hA5A5, 1'b0};
        vecs[10] = '{1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b0};

        reset = 1'b0;
        req = 0; wnotr = 0; addr = 0; wdata = 0;
        req1 = 0; wnotr1 = 0; addr1 = 0; wdata1 = 0;
        req15 = 0; wnotr15 = 0; addr15 = 0; wdata15 = 0;
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_ack", {31'h0, ack}, 32'd0);
        check("reset_rdata", {16'h0, rdata}, 32'd0);
        check("reset_busy", {31'h0, busy}, 32'd0);
        check("reset_busy_l1", {31'h0, busy1}, 32'd0);
        check("reset_rdata_l15", {16'h0, rdata15}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_req(vecs[i]);
        end

        // Reset while the store to 0x0020 is still waiting: no write, outputs drop at once.
        @(negedge clk);
        req = 1'b1; wnotr = 1'b1; addr = 16'h0020; wdata = 16'h1234;
        @(negedge clk);
        req = 1'b0;
        check("busy_before_abort", {31'h0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_ack", {31'h0, ack}, 32'd0);
        check("abort_rdata", {16'h0, rdata}, 32'd0);
        check("abort_busy", {31'h0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_stays_idle", {31'h0, busy}, 32'd0);
        run_req('{1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b0});

        // LATENCY=1 with req held high: acks every third cycle, fields switch between requests.
        ackmask = 0;
        @(negedge clk);
        req1 = 1'b1; wnotr1 = 1'b1; addr1 = 16'h0001; wdata1 = 16'h1001;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ack1 === 1'b1) ackmask = ackmask | (1 << k);
            if (k == 0) check("l1_busy_after_accept", {31'h0, busy1}, 32'd1);
            if (k == 1) begin
                check("l1_rdata_first", {16'h0, rdata1}, 32'h1001);
                addr1 = 16'h0002; wdata1 = 16'h2002;
            end
            if (k == 4) check("l1_rdata_second", {16'h0, rdata1}, 32'h2002);
            if (k == 7) begin
                check("l1_rdata_third", {16'h0, rdata1}, 32'h2002);
                req1 = 1'b0;
            end
        end
        check("l1_ack_pattern", ackmask, 32'b0010010010);

        first = -1;
        @(negedge clk);
        req1 = 1'b1; wnotr1 = 1'b0; addr1 = 16'h0001; wdata1 = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) req1 = 1'b0;
            if (ack1 === 1'b1 && first < 0) first = k;
        end
        check("l1_load_latency", first, 32'd1);
        check("l1_load_rdata", {16'h0, rdata1}, 32'h1001);

        // LATENCY=15: store then load, exactly one ack per request at 15 edges.
        for (int op = 0; op < 2; op++) begin
            first = -1;
            nacks = 0;
            @(negedge clk);
            req15 = 1'b1; wnotr15 = (op == 0); addr15 = 16'h0100;
            wdata15 = (op == 0) ? 16'hC0DE : 16'h0000;
            for (int k = 0; k < 24; k++) begin
                @(negedge clk);
                if (k == 0) req15 = 1'b0;
                if (ack15 === 1'b1) begin
                    nacks++;
                    if (first < 0) first = k;
                end
            end
            check("l15_ack_latency", first, 32'd15);
            check("l15_ack_count", nacks, 32'd1);
            check("l15_rdata", {16'h0, rdata15}, 32'hC0DE);
        end

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
